calc_stack_core: RTL and testbench
==================================

CALC_STACK_CORE -- requirements
Module: calc_stack_core

Interface
REQ-001: Parameter WIDTH, default 16, operand/result width in bits (4..32).
REQ-002: Parameter DEPTH, default 4, operand stack entries (2..16).
REQ-003: clk  input  1  single clock; all state updates on rising edge.
REQ-004: rst  input  1  asynchronous, active-high reset.
REQ-005: op_valid  input  1  command offered this cycle.
REQ-006: op_ready  output  1  core accepts a command this cycle; a command transfers when op_valid && op_ready.
REQ-007: op_code  input  3  command: PUSH, ADD, SUB, MUL, DUP, SWAP, DROP, CLEAR.
REQ-008: op_data  input  WIDTH  operand for PUSH; ignored otherwise.
REQ-009: top  output  WIDTH  current top-of-stack, 0 when empty.
REQ-010: count  output  $clog2(DEPTH+1)  number of valid stack entries.
REQ-011: done  output  1  one-cycle pulse when a command retires.
REQ-012: err  output  2  status of last retired command: OK, UNDERFLOW, OVERFLOW, UNSUPPORTED; held until next retirement.
REQ-013: carry  output  1  carry/borrow/high-product-nonzero flag of last retired arithmetic command; held until next arithmetic retirement.

Function
REQ-014: FSM states IDLE and MUL_RUN; op_ready = 1 only in IDLE.
REQ-015: Non-MUL commands retire in the acceptance cycle; done pulses the following cycle with stack, top, count, err, carry updated simultaneously.
REQ-016: PUSH: full stack -> err=OVERFLOW, stack unchanged; else push op_data.
REQ-017: ADD/SUB: need count>=2, else err=UNDERFLOW, stack unchanged; pop b (top), a (next), push a+b or a-b modulo 2^WIDTH; carry = carry-out (ADD) or borrow, a<b (SUB).
REQ-018: DUP: count==0 -> UNDERFLOW; count==DEPTH -> OVERFLOW; else push copy of top.
REQ-019: SWAP: count<2 -> UNDERFLOW; else exchange top two entries.
REQ-020: DROP: count==0 -> UNDERFLOW; else pop.
REQ-021: CLEAR: count=0, top=0, err=OK, carry=0; never errors.
REQ-022: MUL: count<2 -> UNDERFLOW, retires in one cycle as REQ-015; else enter MUL_RUN for exactly WIDTH cycles (shift-add), then return to IDLE, replace top two with low WIDTH bits of a*b; carry=1 iff high WIDTH bits nonzero; done pulses on the cycle IDLE is re-entered.
REQ-023: During MUL_RUN op_valid is ignored (not accepted); stack and top hold pre-MUL values until retirement.
REQ-024: Error retirements still pulse done; stack contents never partially modified.
REQ-025: Undefined op_code encodings retire with err=UNSUPPORTED, stack unchanged.

Reset
REQ-026: rst asserted (any time, including mid-MUL_RUN) -> state IDLE, count=0, top=0, done=0, err=OK, carry=0, op_ready=0 while rst high, 1 first cycle after release; in-flight MUL discarded.
REQ-027: Stack storage below count need not be reset.

Configuration
REQ-028: Macro CALC_STACK_MUL_EN: defined -> MUL as REQ-022 with multiplier instantiated; undefined -> no multiplier logic, MUL_RUN never entered, MUL retires in one cycle with err=UNSUPPORTED, stack unchanged.

Structure
REQ-029: Package calc_pkg holds opcode enum, err code enum and FSM state type; shared with other calculator blocks.
REQ-030: One sub-module calc_shift_mul (WIDTH-parameterised sequential shift-add multiplier, start/busy/done), instantiated only under CALC_STACK_MUL_EN.

Verification (WIDTH=16, DEPTH=4)
REQ-031: PUSH 7, PUSH 5, SUB -> top=2, count=1, carry=0, err=OK; then PUSH 9, SUB -> top=0xFFF9, carry=1.
REQ-032: PUSH 0xFFFF, PUSH 1, ADD -> top=0, carry=1, count=1.
REQ-033: PUSH 1..4 then PUSH 5 -> err=OVERFLOW, count=4, top=4; DROP x4 then DROP -> err=UNDERFLOW, count=0, top=0.
REQ-034: PUSH 300, PUSH 300, MUL -> op_ready low exactly 16 cycles, done then top=0x5F90, carry=1; op_valid held high during MUL_RUN not accepted.
REQ-035: rst pulsed at MUL_RUN cycle 8 -> count=0, top=0, no done pulse, op_ready=1 after release.
REQ-036: Build without CALC_STACK_MUL_EN: PUSH 3, PUSH 4, MUL -> one-cycle retire, err=UNSUPPORTED, count=2, top=4.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared calculator types: command encodings, status codes and core FSM states.
package calc_pkg;

    typedef enum logic [2:0] {
        OP_PUSH  = 3'd0,
        OP_ADD   = 3'd1,
        OP_SUB   = 3'd2,
        OP_MUL   = 3'd3,
        OP_DUP   = 3'd4,
        OP_SWAP  = 3'd5,
        OP_DROP  = 3'd6,
        OP_CLEAR = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        ERR_OK          = 2'd0,
        ERR_UNDERFLOW   = 2'd1,
        ERR_OVERFLOW    = 2'd2,
        ERR_UNSUPPORTED = 2'd3
    } err_e;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MUL_RUN = 1'b1
    } state_e;

endpackage

// File: rtl/calc_shift_mul.sv
// Sequential shift-add multiplier: one partial product per cycle, WIDTH cycles per
// product. done is asserted during the final step and product carries the complete
// result in that same cycle, so the consumer can capture it on the closing edge.
module calc_shift_mul #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] addend;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;

    assign addend  = mplier_q[0] ? mcand_q : '0;
    assign product = acc_q + addend;
    assign done    = busy_q && (cnt_q == CNT_W'(1));
    assign busy    = busy_q;

    // Load operands on start, then add one shifted multiplicand per remaining bit.
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (start) begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            cnt_d    = CNT_W'(WIDTH);
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = acc_q + addend;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CNT_W'(1);
            busy_d   = (cnt_q != CNT_W'(1));
        end
    end

    // Control state is reset so an aborted product never reports completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    // Datapath registers carry no reset; they are always reloaded by start.
    always_ff @(posedge clk) begin
        acc_q    <= acc_d;
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
    end

endmodule

// File: rtl/calc_stack_core.sv
// Stack-based integer calculator core with a valid/ready command port.
// Optional feature macro: CALC_STACK_MUL_EN enables MUL via the sequential
// shift-add multiplier; without it MUL retires at once as UNSUPPORTED.
module calc_stack_core
    import calc_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       op_valid,
    output logic                       op_ready,
    input  logic [2:0]                 op_code,
    input  logic [WIDTH-1:0]           op_data,
    output logic [WIDTH-1:0]           top,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       done,
    output logic [1:0]                 err,
    output logic                       carry
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] ONE = CW'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] stack_q [DEPTH];
    logic [WIDTH-1:0] stack_d [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    err_e             err_q, err_d;
    logic             carry_q, carry_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] tos, nos, diff;
    logic [WIDTH:0]   add_w;
    opcode_e          opc;
    logic             accept;
    logic             mul_idle;
    int               cnt;

    assign cnt    = int'(count_q);
    assign opc    = opcode_e'(op_code);
    assign accept = op_valid && op_ready;
    assign add_w  = {1'b0, nos} + {1'b0, tos};
    assign diff   = nos - tos;

`ifdef CALC_STACK_MUL_EN
    logic               mul_start, mul_busy, mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    assign mul_start = accept && (opc == OP_MUL) && (cnt >= 2);
    assign mul_idle  = !mul_busy;

    calc_shift_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (nos),
        .b       (tos),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
    );
`else
    assign mul_idle = 1'b1;
`endif

    // Pick the top two entries; an empty slot reads as zero.
    always_comb begin
        tos = '0;
        nos = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i == cnt - 1) tos = stack_q[i];
            if (i == cnt - 2) nos = stack_q[i];
        end
    end

    // Stack update and status for each retiring command; errors leave the stack intact.
    always_comb begin
        stack_d = stack_q;
        count_d = count_q;
        err_d   = err_q;
        carry_d = carry_q;
        done_d  = 1'b0;
`ifdef CALC_STACK_MUL_EN
        if (state_q == ST_MUL_RUN) begin
            if (mul_done) begin
                for (int i = 0; i < DEPTH; i++)
                    if (i == cnt - 2) stack_d[i] = mul_prod[WIDTH-1:0];
                count_d = count_q - ONE;
                err_d   = ERR_OK;
                carry_d = |mul_prod[2*WIDTH-1:WIDTH];
                done_d  = 1'b1;
            end
        end else
`endif
        if (accept) begin
            done_d = 1'b1;
            err_d  = ERR_OK;
            case (opc)
                OP_PUSH: begin
                    if (cnt == DEPTH) begin
                        err_d = ERR_OVERFLOW;
                    end else begin
                        for (int i = 0; i < DEPTH; i++)
                            if (i == cnt) stack_d[i] = op_data;
                        count_d = count_q + ONE;
                    end
                end
                OP_ADD, OP_SUB: begin
                    if (cnt < 2) begin
                        err_d = ERR_UNDERFLOW;
                    end else begin
                        for (int i = 0; i < DEPTH; i++)
                            if (i == cnt - 2)
                                stack_d[i] = (opc == OP_ADD) ? add_w[WIDTH-1:0] : diff;
                        count_d = count_q - ONE;
                        carry_d = (opc == OP_ADD) ? add_w[WIDTH] : (nos < tos);
                    end
                end
                OP_MUL: begin
`ifdef CALC_STACK_MUL_EN
                    if (cnt < 2) begin
                        err_d = ERR_UNDERFLOW;
                    end else begin
                        // Retirement is deferred to the end of the multiply.
                        done_d = 1'b0;
                        err_d  = err_q;
                    end
`else
                    err_d = ERR_UNSUPPORTED;
`endif
                end
                OP_DUP: begin
                    if (cnt == 0) begin
                        err_d = ERR_UNDERFLOW;
                    end else if (cnt == DEPTH) begin
                        err_d = ERR_OVERFLOW;
                    end else begin
                        for (int i = 0; i < DEPTH; i++)
                            if (i == cnt) stack_d[i] = tos;
                        count_d = count_q + ONE;
                    end
                end
                OP_SWAP: begin
                    if (cnt < 2) begin
                        err_d = ERR_UNDERFLOW;
                    end else begin
                        for (int i = 0; i < DEPTH; i++) begin
                            if (i == cnt - 1) stack_d[i] = nos;
                            if (i == cnt - 2) stack_d[i] = tos;
                        end
                    end
                end
                OP_DROP: begin
                    if (cnt == 0) err_d = ERR_UNDERFLOW;
                    else          count_d = count_q - ONE;
                end
                OP_CLEAR: begin
                    count_d = '0;
                    carry_d = 1'b0;
                end
                default: err_d = ERR_UNSUPPORTED;
            endcase
        end
    end

    // FSM next state: a valid MUL parks the core until the multiplier finishes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
`ifdef CALC_STACK_MUL_EN
                if (mul_start) state_d = ST_MUL_RUN;
`endif
            end
            ST_MUL_RUN: begin
`ifdef CALC_STACK_MUL_EN
                if (mul_done) state_d = ST_IDLE;
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: commands are only taken in IDLE and never while reset is held.
    always_comb begin
        op_ready = (state_q == ST_IDLE) && mul_idle && !rst;
        top      = tos;
        count    = count_q;
        done     = done_q;
        err      = err_q;
        carry    = carry_q;
    end

    // Control and status registers; reset discards any in-flight multiply.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            err_q   <= ERR_OK;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            err_q   <= err_d;
            carry_q <= carry_d;
            done_q  <= done_d;
        end
    end

    // Stack storage is qualified by count, so it needs no reset.
    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end

endmodule

// File: tb/tb_calc_stack_core.sv
// Directed bench for calc_stack_core (WIDTH=16, DEPTH=4). Expected results are
// queued when a command is driven and compared when done pulses. Follows the
// CALC_STACK_MUL_EN build setting for the MUL scenarios.
module tb_calc_stack_core;
    import calc_pkg::*;

    logic        clk;
    logic        rst;
    logic        op_valid;
    logic        op_ready;
    logic [2:0]  op_code;
    logic [15:0] op_data;
    logic [15:0] top;
    logic [2:0]  count;
    logic        done;
    logic [1:0]  err;
    logic        carry;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        logic [15:0] top;
        logic [2:0]  count;
        logic [1:0]  err;
        logic        carry;
        bit          chk_carry;
    } exp_t;

    exp_t sb[$];

    calc_stack_core #(.WIDTH(16), .DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_code  (op_code),
        .op_data  (op_data),
        .top      (top),
        .count    (count),
        .done     (done),
        .err      (err),
        .carry    (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic expect_push(input string tag, input logic [15:0] t, input logic [2:0] c,
                               input err_e e, input logic cy, input bit chk_cy);
        exp_t x;
        x.tag = tag; x.top = t; x.count = c; x.err = e; x.carry = cy; x.chk_carry = chk_cy;
        sb.push_back(x);
    endtask

    // Compare the oldest expectation against the outputs present while done is high.
    task automatic retire_check();
        exp_t x;
        if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
            return;
        end
        x = sb.pop_front();
        check({x.tag, "_done"}, done, 1'b1);
        check({x.tag, "_top"}, top, x.top);
        check({x.tag, "_count"}, count, x.count);
        check({x.tag, "_err"}, err, x.err);
        if (x.chk_carry) check({x.tag, "_carry"}, carry, x.carry);
    endtask

    // Issue one single-cycle command and wait (bounded) for its done pulse.
    task automatic step(input opcode_e code, input logic [15:0] data, input string tag,
                        input logic [15:0] t, input logic [2:0] c, input err_e e,
                        input logic cy, input bit chk_cy);
        int n;
        expect_push(tag, t, c, e, cy, chk_cy);
        op_code  = code;
        op_data  = data;
        op_valid = 1'b1;
        n = 0;
        while (!op_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!op_ready) check({tag, "_ready_wait"}, op_ready, 1'b1);
        @(posedge clk); #1;
        op_valid = 1'b0;
        n = 0;
        while (!done && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check({tag, "_latency"}, n, 0);
        retire_check();
    endtask

    initial begin
        int lowc;
        int dcnt;
        rst      = 1'b1;
        op_valid = 1'b0;
        op_code  = OP_PUSH;
        op_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", op_ready, 1'b0);
        check("rst_count", count, 3'd0);
        check("rst_top", top, 16'h0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, ERR_OK);
        check("rst_carry", carry, 1'b0);
        rst = 1'b0;
        #1;
        check("rel_ready", op_ready, 1'b1);

        // Subtraction with and without borrow
        step(OP_PUSH, 16'd7, "push7", 16'd7, 3'd1, ERR_OK, 1'b0, 1'b0);
        step(OP_PUSH, 16'd5, "push5", 16'd5, 3'd2, ERR_OK, 1'b0, 1'b0);
        step(OP_SUB,  16'd0, "sub_7_5", 16'd2, 3'd1, ERR_OK, 1'b0, 1'b1);
        step(OP_PUSH, 16'd9, "push9", 16'd9, 3'd2, ERR_OK, 1'b0, 1'b0);
        step(OP_SUB,  16'd0, "sub_2_9", 16'hFFF9, 3'd1, ERR_OK, 1'b1, 1'b1);
        step(OP_CLEAR, 16'd0, "clear1", 16'd0, 3'd0, ERR_OK, 1'b0, 1'b1);

        // Addition wrapping with carry-out
        step(OP_PUSH, 16'hFFFF, "pushFFFF", 16'hFFFF, 3'd1, ERR_OK, 1'b0, 1'b0);
        step(OP_PUSH, 16'd1, "push1a", 16'd1, 3'd2, ERR_OK, 1'b0, 1'b0);
        step(OP_ADD,  16'd0, "add_wrap", 16'd0, 3'd1, ERR_OK, 1'b1, 1'b1);
        step(OP_CLEAR, 16'd0, "clear2", 16'd0, 3'd0, ERR_OK, 1'b0, 1'b1);

        // Fill to full, overflow attempts, swaps, drain and underflow attempts
        for (int i = 1; i <= 4; i++)
            step(OP_PUSH, 16'(i), "fill", 16'(i), 3'(i), ERR_OK, 1'b0, 1'b0);
        step(OP_PUSH, 16'd5, "push_full", 16'd4, 3'd4, ERR_OVERFLOW, 1'b0, 1'b0);
        step(OP_DUP,  16'd0, "dup_full", 16'd4, 3'd4, ERR_OVERFLOW, 1'b0, 1'b0);
        step(OP_SWAP, 16'd0, "swap1", 16'd3, 3'd4, ERR_OK, 1'b0, 1'b0);
        step(OP_SWAP, 16'd0, "swap2", 16'd4, 3'd4, ERR_OK, 1'b0, 1'b0);
        for (int i = 3; i >= 0; i--)
            step(OP_DROP, 16'd0, "drain", 16'(i), 3'(i), ERR_OK, 1'b0, 1'b0);
        step(OP_DROP, 16'd0, "drop_empty", 16'd0, 3'd0, ERR_UNDERFLOW, 1'b0, 1'b0);
        step(OP_SWAP, 16'd0, "swap_empty", 16'd0, 3'd0, ERR_UNDERFLOW, 1'b0, 1'b0);
        step(OP_ADD,  16'd0, "add_empty", 16'd0, 3'd0, ERR_UNDERFLOW, 1'b0, 1'b0);
        step(OP_DUP,  16'd0, "dup_empty", 16'd0, 3'd0, ERR_UNDERFLOW, 1'b0, 1'b0);

        // DUP then ADD of the copy
        step(OP_PUSH, 16'd6, "push6", 16'd6, 3'd1, ERR_OK, 1'b0, 1'b0);
        step(OP_SUB,  16'd0, "sub_one", 16'd6, 3'd1, ERR_UNDERFLOW, 1'b0, 1'b0);
        step(OP_DUP,  16'd0, "dup6", 16'd6, 3'd2, ERR_OK, 1'b0, 1'b0);
        step(OP_ADD,  16'd0, "add_6_6", 16'd12, 3'd1, ERR_OK, 1'b0, 1'b1);
        step(OP_CLEAR, 16'd0, "clear3", 16'd0, 3'd0, ERR_OK, 1'b0, 1'b1);

`ifdef CALC_STACK_MUL_EN
        // Multi-cycle multiply with a command held on the port throughout
        step(OP_PUSH, 16'd300, "push300a", 16'd300, 3'd1, ERR_OK, 1'b0, 1'b0);
        step(OP_PUSH, 16'd300, "push300b", 16'd300, 3'd2, ERR_OK, 1'b0, 1'b0);
        expect_push("mul", 16'h5F90, 3'd1, ERR_OK, 1'b1, 1'b1);
        op_code  = OP_MUL;
        op_valid = 1'b1;
        @(posedge clk); #1;
        op_code = OP_PUSH;
        op_data = 16'hAAAA;
        lowc = 0;
        dcnt = 0;
        while (!op_ready && lowc < 40) begin
            if (done) dcnt++;
            if (lowc == 8) begin
                check("mul_hold_top", top, 16'd300);
                check("mul_hold_count", count, 3'd2);
            end
            @(posedge clk); #1;
            lowc++;
        end
        op_valid = 1'b0;
        check("mul_ready_low", lowc, 16);
        check("mul_early_done", dcnt, 0);
        retire_check();
        @(posedge clk); #1;
        check("mul_done_pulse", done, 1'b0);
        check("mul_no_accept", count, 3'd1);

        // Reset in the middle of a multiply
        step(OP_PUSH, 16'd300, "push300c", 16'd300, 3'd2, ERR_OK, 1'b0, 1'b0);
        step(OP_PUSH, 16'd300, "push300d", 16'd300, 3'd3, ERR_OK, 1'b0, 1'b0);
        op_code  = OP_MUL;
        op_valid = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("mrun_ready_low", op_ready, 1'b0);
        rst = 1'b1;
        #1;
`else
        // MUL unavailable: retires at once without touching the stack
        step(OP_PUSH, 16'd3, "push3", 16'd3, 3'd1, ERR_OK, 1'b0, 1'b0);
        step(OP_PUSH, 16'd4, "push4", 16'd4, 3'd2, ERR_OK, 1'b0, 1'b0);
        step(OP_MUL,  16'd0, "mul_unsup", 16'd4, 3'd2, ERR_UNSUPPORTED, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("mul_done_pulse", done, 1'b0);

        // Reset with a populated stack
        rst = 1'b1;
        #1;
`endif
        check("arst_ready", op_ready, 1'b0);
        check("arst_count", count, 3'd0);
        check("arst_top", top, 16'd0);
        check("arst_done", done, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("arel_ready", op_ready, 1'b1);
        dcnt = 0;
        repeat (24) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        check("arel_no_done", dcnt, 0);
        check("arel_count", count, 3'd0);
        check("arel_err", err, ERR_OK);
        check("arel_carry", carry, 1'b0);
        check("arel_ready2", op_ready, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
